// File: rtl/sad_diff_accumulator.sv
// Sum of absolute differences over a frame of COUNT pixel pairs, with valid/ready
// on both sides. The pipeline has three registers: input capture, |a-b|, and accumulate.
module sad_diff_accumulator #(
  parameter int WIDTH = 8,
  parameter int COUNT = 16,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sad,
  output logic             overflow,
  output logic             busy
);

  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             p0_valid;
  logic [WIDTH-1:0] s1_diff;
  logic             s1_valid;
  logic [ACC_W-1:0] acc;
  logic             acc_ovf;

  logic [WIDTH:0]   d;
  logic             borrow;
  logic [WIDTH-1:0] abs_diff;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_next;
  logic             ovf_next;
  logic             take;
  logic             last_pair;

  always_comb begin
    // a - b as a + ~b + 1; a clear carry-out means the subtraction borrowed
    d        = {1'b0, a_reg} + {1'b0, ~b_reg} + (WIDTH+1)'(1);
    borrow   = ~d[WIDTH];
    abs_diff = borrow ? (b_reg - a_reg) : d[WIDTH-1:0];
    sum      = {1'b0, acc} + (ACC_W+1)'(s1_diff);
    acc_next = sum[ACC_W] ? ACC_MAX : sum[ACC_W-1:0];
    ovf_next = acc_ovf | sum[ACC_W];
    take     = in_valid && in_ready;
    last_pair = (cnt == CNT_W'(COUNT - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sad       <= '0;
      overflow  <= 1'b0;
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      p0_valid  <= 1'b0;
      s1_diff   <= '0;
      s1_valid  <= 1'b0;
      acc       <= '0;
      acc_ovf   <= 1'b0;
    end else begin
      p0_valid <= take;
      if (take) begin
        a_reg <= a;
        b_reg <= b;
        cnt   <= cnt + CNT_W'(1);
      end
      s1_valid <= p0_valid;
      if (p0_valid) s1_diff <= abs_diff;
      if (s1_valid) begin
        acc     <= acc_next;
        acc_ovf <= ovf_next;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state    <= ACCUM;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            acc      <= '0;
            acc_ovf  <= 1'b0;
            cnt      <= '0;
          end
        end
        ACCUM: begin
          if (take && last_pair) begin
            state    <= DRAIN;
            in_ready <= 1'b0;
          end
        end
        DRAIN: begin
          // Done once the final difference is being folded in and nothing is behind it
          if (s1_valid && !p0_valid) begin
            state     <= DONE;
            out_valid <= 1'b1;
            sad       <= acc_next;
            overflow  <= ovf_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_diff_accumulator.sv
// Bench for sad_diff_accumulator: three instances (default, narrow accumulator, COUNT=1)
// share stimulus; a select picks which one is driven and observed.
module tb_sad_diff_accumulator;

  typedef struct {
    int sel;
    int a;
    int b;
    int exp_sad;
    int exp_ovf;
  } vec_t;

  typedef struct {
    int sad;
    int ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [7:0] a = '0, b = '0;
  int sel = 0;
  int cyc = 0;
  int n_vec = 0;
  int n_fail = 0;
  res_t sb[$];
  logic [7:0] pa[16];
  logic [7:0] pb[16];

  logic start0, start1, start2, iv0, iv1, iv2;
  logic ir0, ir1, ir2, ov0, ov1, ov2, of0, of1, of2, bz0, bz1, bz2;
  logic [11:0] sad0, sad2;
  logic [9:0] sad1;
  logic cur_in_ready, cur_out_valid, cur_ovf, cur_busy;
  int cur_sad;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign start0 = start && (sel == 0);
  assign start1 = start && (sel == 1);
  assign start2 = start && (sel == 2);
  assign iv0 = in_valid && (sel == 0);
  assign iv1 = in_valid && (sel == 1);
  assign iv2 = in_valid && (sel == 2);

  always_comb begin
    cur_in_ready  = ir0;
    cur_out_valid = ov0;
    cur_ovf       = of0;
    cur_busy      = bz0;
    cur_sad       = int'(sad0);
    if (sel == 1) begin
      cur_in_ready = ir1; cur_out_valid = ov1; cur_ovf = of1; cur_busy = bz1; cur_sad = int'(sad1);
    end else if (sel == 2) begin
      cur_in_ready = ir2; cur_out_valid = ov2; cur_ovf = of2; cur_busy = bz2; cur_sad = int'(sad2);
    end
  end

  sad_diff_accumulator #(.WIDTH(8), .COUNT(16), .ACC_W(12)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b),
    .out_valid(ov0), .out_ready(out_ready), .sad(sad0), .overflow(of0), .busy(bz0));
  sad_diff_accumulator #(.WIDTH(8), .COUNT(16), .ACC_W(10)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
    .out_valid(ov1), .out_ready(out_ready), .sad(sad1), .overflow(of1), .busy(bz1));
  sad_diff_accumulator #(.WIDTH(8), .COUNT(1), .ACC_W(12)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(iv2), .in_ready(ir2), .a(a), .b(b),
    .out_valid(ov2), .out_ready(out_ready), .sad(sad2), .overflow(of2), .busy(bz2));

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (sel=%0d cyc=%0d)", name, act, exp, sel, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: saturating sum of |a-b| over the first n pairs in pa/pb
  task automatic push_model(input int s, input int n);
    int mx, sum, ovf, d;
    res_t r;
    mx = (s == 1) ? 1023 : 4095;
    sum = 0;
    ovf = 0;
    for (int i = 0; i < n; i++) begin
      d = (pa[i] > pb[i]) ? int'(pa[i]) - int'(pb[i]) : int'(pb[i]) - int'(pa[i]);
      sum += d;
      if (sum > mx) begin
        sum = mx;
        ovf = 1;
      end
    end
    r.sad = sum;
    r.ovf = ovf;
    sb.push_back(r);
  endtask

  task automatic run_frame(input int s, input int n, input bit gaps, input int hold);
    int accepted, last_acc, t;
    bit go;
    res_t e;
    sel = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", int'(cur_busy), 1);
    accepted = 0;
    last_acc = 0;
    t = 0;
    while (accepted < n && t < 1000) begin
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      a = pa[accepted];
      b = pb[accepted];
      go = in_valid && cur_in_ready;
      tick();
      if (go) begin
        accepted++;
        last_acc = cyc;
      end
      t++;
    end
    in_valid = 1'b0;
    if (t >= 1000) check("accept_timeout", accepted, n);
    out_ready = (hold == 0);
    t = 0;
    while (!cur_out_valid && t < 20) begin
      check("in_ready_drain", int'(cur_in_ready), 0);
      start = (hold > 0);
      tick();
      t++;
    end
    start = 1'b0;
    if (!cur_out_valid) begin
      check("out_valid_timeout", int'(cur_out_valid), 1);
      return;
    end
    check("latency", cyc - last_acc, 2);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 0, 1);
      return;
    end
    e = sb.pop_front();
    check("sad", cur_sad, e.sad);
    check("overflow", int'(cur_ovf), e.ovf);
    for (int i = 0; i < hold; i++) begin
      start = 1'b1;
      tick();
      check("held_out_valid", int'(cur_out_valid), 1);
      check("held_sad", cur_sad, e.sad);
      check("held_in_ready", int'(cur_in_ready), 0);
    end
    out_ready = 1'b1;
    start = (hold > 0);
    tick();
    start = 1'b0;
    out_ready = 1'b0;
    check("out_valid_after_xfer", int'(cur_out_valid), 0);
    check("busy_after_xfer", int'(cur_busy), 0);
    check("sad_kept", cur_sad, e.sad);
    $display("frame sel=%0d n=%0d gaps=%0d hold=%0d sad=%0d ovf=%0d", s, n, gaps, hold, cur_sad, cur_ovf);
  endtask

  vec_t tbl[7];
  res_t r;

  initial begin
    tbl[0] = '{sel: 0, a: 200, b: 55,  exp_sad: 2320, exp_ovf: 0};
    tbl[1] = '{sel: 0, a: 55,  b: 200, exp_sad: 2320, exp_ovf: 0};
    tbl[2] = '{sel: 0, a: 0,   b: 255, exp_sad: 4080, exp_ovf: 0};
    tbl[3] = '{sel: 1, a: 0,   b: 255, exp_sad: 1023, exp_ovf: 1};
    tbl[4] = '{sel: 0, a: 5,   b: 4,   exp_sad: 16,   exp_ovf: 0};
    tbl[5] = '{sel: 2, a: 7,   b: 9,   exp_sad: 2,    exp_ovf: 0};
    tbl[6] = '{sel: 0, a: 77,  b: 77,  exp_sad: 0,    exp_ovf: 0};

    #12;
    check("rst_in_ready", int'(ir0), 0);
    check("rst_out_valid", int'(ov0), 0);
    check("rst_sad", int'(sad0), 0);
    check("rst_busy", int'(bz0), 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    foreach (tbl[i]) begin
      for (int k = 0; k < 16; k++) begin
        pa[k] = 8'(tbl[i].a);
        pb[k] = 8'(tbl[i].b);
      end
      r.sad = tbl[i].exp_sad;
      r.ovf = tbl[i].exp_ovf;
      sb.push_back(r);
      run_frame(tbl[i].sel, (tbl[i].sel == 2) ? 1 : 16, 1'b0, 0);
    end

    // Reset in the middle of a frame, after a nonzero result is held on sad
    for (int k = 0; k < 16; k++) begin
      pa[k] = 8'(200);
      pb[k] = 8'(55);
    end
    sb.push_back('{sad: 2320, ovf: 0});
    run_frame(0, 16, 1'b0, 0);
    sel = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    repeat (5) tick();
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_in_ready", int'(cur_in_ready), 0);
    check("async_rst_busy", int'(cur_busy), 0);
    check("async_rst_sad", cur_sad, 0);
    check("async_rst_ovf", int'(cur_ovf), 0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    check("post_rst_out_valid", int'(cur_out_valid), 0);
    check("post_rst_busy", int'(cur_busy), 0);

    // Random pixels, gapped input and held-off output on both accumulator widths
    for (int f = 0; f < 6; f++) begin
      for (int k = 0; k < 16; k++) begin
        pa[k] = 8'($urandom_range(0, 255));
        pb[k] = 8'($urandom_range(0, 255));
      end
      push_model(f % 2, 16);
      run_frame(f % 2, 16, 1'b1, (f < 2) ? 10 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cyc=%0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
